// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet layout, address field bounds and the
// round-robin pick helper used by the decoder and arbiter blocks.
package noc_pkg;

    localparam int unsigned DATA_W   = 9;
    localparam int unsigned ADDR_MSB = 8;
    localparam int unsigned ADDR_LSB = 5;
    localparam int unsigned MAX_N    = 8;
    localparam int unsigned IDX_W    = 3;

    typedef logic [DATA_W-1:0] pkt_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req[n-1:0], scanning upward from (last+1) mod n with wrap.
    function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] req,
                                         input logic [IDX_W-1:0] last,
                                         input int unsigned      n);
        rr_pick_t    r;
        int unsigned cand;
        r = '0;
        for (int unsigned i = 1; i <= MAX_N; i++) begin
            cand = (32'(last) + i) % n;
            if ((i <= n) && !r.found && req[cand]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(cand);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_rr_merge_arbiter_if.sv
// Handshake bundle for the N:1 merge arbiter.
//   master: requester/downstream side (drives in_valid, in_data, out_ready)
//   slave : arbiter side (drives in_ready, out_valid, out_data, out_src, conflict_cnt)
interface noc_rr_merge_arbiter_if #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned DATA_W = 9,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0]        in_valid;
    logic [N_IN*DATA_W-1:0] in_data;
    logic [N_IN-1:0]        in_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_src;
    logic                   out_ready;
    logic [CNT_W-1:0]       conflict_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src, conflict_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src, conflict_cnt
    );
endinterface

// File: rtl/noc_fifo2.sv
// 2-entry synchronous FIFO, head presented straight from registers.
// Ports: clk, rst_n (sync, active-low), push/push_data, pop,
//        count (registered occupancy), head_valid, head_data.
// Push is ignored when full; callers derive space from count, so there is
// no combinational pop->space path.
module noc_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic         head_valid,
    output logic [W-1:0] head_data
);
    logic [W-1:0] tail_q;
    logic [W-1:0] head_n;
    logic [W-1:0] tail_n;
    logic [1:0]   count_n;

    // Next-state: head/tail shift structure keeps ordering on push+pop.
    always_comb begin
        head_n  = head_data;
        tail_n  = tail_q;
        count_n = count;
        case (count)
            2'd0: begin
                if (push) begin
                    head_n  = push_data;
                    count_n = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_n = push_data;
                end else if (push) begin
                    tail_n  = push_data;
                    count_n = 2'd2;
                end else if (pop) begin
                    count_n = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_n  = tail_q;
                    count_n = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= 2'd0;
            head_valid <= 1'b0;
            head_data  <= '0;
            tail_q     <= '0;
        end else begin
            count      <= count_n;
            head_valid <= (count_n != 2'd0);
            head_data  <= head_n;
            tail_q     <= tail_n;
        end
    end
endmodule

// File: rtl/noc_rr_merge_arbiter.sv
// N:1 round-robin merge arbiter feeding one downstream link through a
// 2-entry output queue, plus a saturating contention counter.
// Ports: clk, rst_n (sync, active-low), bus (slave modport):
//   in_valid/in_data/in_ready per input, out_valid/out_data/out_src/out_ready
//   downstream, conflict_cnt = grants issued while more than one input valid.
module noc_rr_merge_arbiter #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned DATA_W = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    noc_rr_merge_arbiter_if.slave bus
);
    import noc_pkg::*;

    localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned ENT_W = SEL_W + DATA_W;

    logic [SEL_W-1:0]  last_grant;
    logic [CNT_W-1:0]  conflict_q;
    logic [1:0]        fifo_cnt;
    logic              head_valid;
    logic [ENT_W-1:0]  head_q;

    rr_pick_t          pick_c;
    logic              grant_c;
    logic [SEL_W-1:0]  gidx_c;
    logic [DATA_W-1:0] gdata_c;
    logic              multi_c;
    logic              pop_c;

    // Arbitration: space comes from the registered count only, so in_ready
    // never sees out_ready; reset holds every in_ready low.
    always_comb begin
        pick_c       = rr_pick(MAX_N'(bus.in_valid), IDX_W'(last_grant), N_IN);
        gidx_c       = SEL_W'(pick_c.idx);
        grant_c      = rst_n && (fifo_cnt < 2'd2) && pick_c.found;
        gdata_c      = bus.in_data[int'(gidx_c)*DATA_W +: DATA_W];
        multi_c      = ($countones(bus.in_valid) > 1);
        pop_c        = head_valid && bus.out_ready;
        bus.in_ready = '0;
        if (grant_c) begin
            bus.in_ready[gidx_c] = 1'b1;
        end
    end

    // Pointer only moves on a grant, so idle cycles keep the priority order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= SEL_W'(N_IN - 1);
            conflict_q <= '0;
        end else if (grant_c) begin
            last_grant <= gidx_c;
            if (multi_c && (conflict_q != '1)) begin
                conflict_q <= conflict_q + CNT_W'(1);
            end
        end
    end

    noc_fifo2 #(
        .W (ENT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (grant_c),
        .push_data  ({gidx_c, gdata_c}),
        .pop        (pop_c),
        .count      (fifo_cnt),
        .head_valid (head_valid),
        .head_data  (head_q)
    );

    assign bus.out_valid    = head_valid;
    assign bus.out_data     = head_q[DATA_W-1:0];
    assign bus.out_src      = head_q[ENT_W-1:DATA_W];
    assign bus.conflict_cnt = conflict_q;
endmodule

// File: tb/tb_noc_rr_merge_arbiter.sv
module tb_noc_rr_merge_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   g0;
    int   g1;

    noc_rr_merge_arbiter_if #(.N_IN(2), .DATA_W(9), .CNT_W(16)) bus  ();
    noc_rr_merge_arbiter_if #(.N_IN(2), .DATA_W(9), .CNT_W(4))  bus2 ();

    noc_rr_merge_arbiter #(.N_IN(2), .DATA_W(9), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    noc_rr_merge_arbiter #(.N_IN(2), .DATA_W(9), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] src, input logic [31:0] data);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_src"},   32'(bus.out_src),   src);
        chk({tag, "_data"},  32'(bus.out_data),  data);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        g0     = 0;
        g1     = 0;

        // Reset with both inputs requesting
        rst_n          = 1'b0;
        bus.in_valid   = 2'b11;
        bus.in_data    = {9'h155, 9'h0A5};
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 2'b00;
        bus2.in_data   = {9'h0F0, 9'h00F};
        bus2.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready",  32'(bus.in_ready),     32'h0);
        chk("rst_out_valid", 32'(bus.out_valid),    32'h0);
        chk("rst_conflict",  32'(bus.conflict_cnt), 32'h0);
        chk("rst_out_data",  32'(bus.out_data),     32'h0);
        chk("rst_out_src",   32'(bus.out_src),      32'h0);
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(bus.in_ready), 32'h1);

        // Alternation with out_ready held high
        tick();
        chk_head("alt1", 32'd0, 32'h0A5);
        chk("alt1_ready", 32'(bus.in_ready), 32'h2);
        tick();
        chk_head("alt2", 32'd1, 32'h155);
        tick();
        chk_head("alt3", 32'd0, 32'h0A5);
        tick();
        chk_head("alt4", 32'd1, 32'h155);
        chk("alt_conflict", 32'(bus.conflict_cnt), 32'd4);
        bus.in_valid = 2'b00;
        tick();
        chk("drain_valid", 32'(bus.out_valid), 32'h0);

        // Backpressure: fill both entries, head must hold
        bus.out_ready = 1'b0;
        bus.in_valid  = 2'b11;
        #1;
        chk("bp_ready0", 32'(bus.in_ready), 32'h1);
        tick();
        chk_head("bp_push1", 32'd0, 32'h0A5);
        chk("bp_conflict1", 32'(bus.conflict_cnt), 32'd5);
        tick();
        chk("bp_full_ready", 32'(bus.in_ready),     32'h0);
        chk("bp_conflict2",  32'(bus.conflict_cnt), 32'd6);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_head("bp_hold", 32'd0, 32'h0A5);
            chk("bp_hold_ready", 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_no_comb_path", 32'(bus.in_ready), 32'h0);
        tick();
        chk_head("bp_pop1", 32'd1, 32'h155);
        chk("bp_regrant", 32'(bus.in_ready), 32'h1);
        tick();
        chk_head("bp_pop2", 32'd0, 32'h0A5);
        chk("bp_conflict3", 32'(bus.conflict_cnt), 32'd7);
        bus.in_valid = 2'b00;
        tick();
        chk("bp_empty", 32'(bus.out_valid), 32'h0);

        // Pointer retention across idle cycles
        bus.in_valid = 2'b10;
        #1;
        chk("ret_single_ready", 32'(bus.in_ready), 32'h2);
        tick();
        chk_head("ret_single", 32'd1, 32'h155);
        chk("ret_conflict_single", 32'(bus.conflict_cnt), 32'd7);
        bus.in_valid = 2'b00;
        tick();
        tick();
        tick();
        chk("ret_idle_valid",    32'(bus.out_valid),    32'h0);
        chk("ret_idle_conflict", 32'(bus.conflict_cnt), 32'd7);
        bus.in_data   = {9'h155, 9'h1F0};
        bus.out_ready = 1'b0;
        bus.in_valid  = 2'b11;
        #1;
        chk("ret_dual_ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk_head("ret_dual", 32'd0, 32'h1F0);
        chk("ret_conflict_dual", 32'(bus.conflict_cnt), 32'd8);

        // Leave last_grant at input 0 with the queue full, then reset
        bus.in_valid = 2'b01;
        #1;
        chk("fill_ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk("fill_full_ready", 32'(bus.in_ready),     32'h0);
        chk("fill_conflict",   32'(bus.conflict_cnt), 32'd8);
        rst_n        = 1'b0;
        bus.in_valid = 2'b11;
        #1;
        chk("mid_rst_ready_low", 32'(bus.in_ready), 32'h0);
        tick();
        chk("mid_rst_valid",    32'(bus.out_valid),    32'h0);
        chk("mid_rst_conflict", 32'(bus.conflict_cnt), 32'h0);
        chk("mid_rst_data",     32'(bus.out_data),     32'h0);
        chk("mid_rst_src",      32'(bus.out_src),      32'h0);
        rst_n         = 1'b1;
        bus.in_data   = {9'h155, 9'h0A5};
        bus.out_ready = 1'b1;
        #1;
        chk("mid_rst_priority", 32'(bus.in_ready), 32'h1);
        tick();
        chk_head("mid_rst_new", 32'd0, 32'h0A5);
        chk("mid_rst_conflict2", 32'(bus.conflict_cnt), 32'd1);
        bus.in_valid = 2'b00;
        tick();
        chk("mid_rst_empty", 32'(bus.out_valid), 32'h0);

        // Saturation and fairness on the 4-bit counter instance
        bus2.in_valid = 2'b11;
        #1;
        for (int k = 1; k <= 20; k++) begin
            if (bus2.in_ready == 2'b01) g0++;
            else if (bus2.in_ready == 2'b10) g1++;
            tick();
            if (k == 1) begin
                chk("sat_head_src",  32'(bus2.out_src),  32'd0);
                chk("sat_head_data", 32'(bus2.out_data), 32'h00F);
            end
            if (k == 14) chk("sat_cnt14", 32'(bus2.conflict_cnt), 32'hE);
            if (k == 15) chk("sat_cnt15", 32'(bus2.conflict_cnt), 32'hF);
            if (k == 20) chk("sat_cnt20", 32'(bus2.conflict_cnt), 32'hF);
        end
        chk("fair_in0", 32'(g0), 32'd10);
        chk("fair_in1", 32'(g1), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
